spi_slave_param: RTL and testbench

- Parametrised, full-duplex SPI slave; next generation of the team's 12-bit receive-only SPI slave.
- Sits at the serial end of the SPI link, clocked directly by the serial clock `sync_clock`.
- Generalised to any word width and either bit order.
- Adds:
  - MISO transmit path with a host-loaded TX buffer.
  - Back-to-back frames while CS stays low.
  - Frame-abort detection.
  - TX underrun flag.

---
 rtl/spi_slave_param.sv | 119 +++++++++++
 tb/tb_spi_slave_param.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_param.sv
// Parametrised full-duplex SPI slave clocked directly by the serial clock.
// Supports back-to-back frames under one chip select, abort detection and TX underrun reporting.
module spi_slave_param #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                  sync_clock,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_pending,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  tx_underrun
);
    localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] tx_buf;
    logic [DATA_WIDTH-1:0] rx_next_c;
    logic [DATA_WIDTH-1:0] tx_next_c;
    logic                  last_bit_c;
    logic                  frame_start_c;

    // Shift direction follows the configured bit order for both RX and TX.
    always_comb begin
        rx_next_c = rx_shift;
        tx_next_c = tx_shift;
        if (LSB_FIRST) begin
            rx_next_c = {mosi, rx_shift[DATA_WIDTH-1:1]};
            tx_next_c = tx_shift >> 1;
        end else begin
            rx_next_c = {rx_shift[DATA_WIDTH-2:0], mosi};
            tx_next_c = tx_shift << 1;
        end
    end

    // The last-bit edge reloads TX for a possible back-to-back frame, so it consumes the buffer too.
    assign last_bit_c    = (state == SHIFT) && !cs && (bit_cnt == LAST_BIT);
    assign frame_start_c = !cs && ((state == IDLE) || last_bit_c);

    assign miso = ~cs & (LSB_FIRST ? tx_shift[0] : tx_shift[DATA_WIDTH-1]);

    always_ff @(posedge sync_clock) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            tx_buf      <= '0;
            tx_shift    <= '0;
            tx_pending  <= 1'b0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;

            // A load on the consuming edge wins: the old word goes out, the new one stays pending.
            if (tx_load) begin
                tx_buf     <= tx_data;
                tx_pending <= 1'b1;
            end else if (frame_start_c) begin
                tx_pending <= 1'b0;
            end
            if (frame_start_c && !tx_pending) begin
                tx_underrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs) begin
                        tx_shift <= tx_buf;
                    end else begin
                        rx_shift <= rx_next_c;
                        tx_shift <= tx_next_c;
                        bit_cnt  <= CNT_W'(1);
                        state    <= SHIFT;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cs) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                        if (bit_cnt != '0) begin
                            frame_err <= 1'b1;
                        end
                    end else if (last_bit_c) begin
                        rx_shift <= rx_next_c;
                        rx_data  <= rx_next_c;
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                        tx_shift <= tx_buf;
                    end else begin
                        rx_shift <= rx_next_c;
                        tx_shift <= tx_next_c;
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: a 12-bit LSB-first and an 8-bit MSB-first instance,
// received words checked against a scoreboard of expected words.
module tb_spi_slave_param;
    logic        sync_clock = 1'b0;
    logic        rst = 1'b0;

    logic        cs12 = 1'b1, mosi12 = 1'b0, tx_load12 = 1'b0;
    logic [11:0] tx_data12 = '0;
    logic        miso12, tx_pending12, rx_valid12, busy12, frame_err12, tx_underrun12;
    logic [11:0] rx_data12;

    logic        cs8 = 1'b1, mosi8 = 1'b0, tx_load8 = 1'b0;
    logic [7:0]  tx_data8 = '0;
    logic        miso8, tx_pending8, rx_valid8, busy8, frame_err8, tx_underrun8;
    logic [7:0]  rx_data8;

    int          checks = 0;
    int          errors = 0;
    int          ferr12 = 0;
    int          und12 = 0;
    logic [11:0] q12[$];
    logic [7:0]  q8[$];

    always #5 sync_clock = ~sync_clock;

    spi_slave_param #(.DATA_WIDTH(12), .LSB_FIRST(1'b1)) dut12 (
        .sync_clock(sync_clock), .rst(rst), .cs(cs12), .mosi(mosi12), .miso(miso12),
        .tx_data(tx_data12), .tx_load(tx_load12), .tx_pending(tx_pending12),
        .rx_data(rx_data12), .rx_valid(rx_valid12), .busy(busy12),
        .frame_err(frame_err12), .tx_underrun(tx_underrun12)
    );

    spi_slave_param #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) dut8 (
        .sync_clock(sync_clock), .rst(rst), .cs(cs8), .mosi(mosi8), .miso(miso8),
        .tx_data(tx_data8), .tx_load(tx_load8), .tx_pending(tx_pending8),
        .rx_data(rx_data8), .rx_valid(rx_valid8), .busy(busy8),
        .frame_err(frame_err8), .tx_underrun(tx_underrun8)
    );

    // One clock edge; outputs sampled 1 ns later and received words popped from the scoreboard.
    task automatic tick();
        logic [11:0] e12;
        logic [7:0]  e8;
        @(posedge sync_clock);
        #1;
        if (rx_valid12 === 1'b1) begin
            checks++;
            if (q12.size() == 0) begin
                errors++;
                $display("FAIL rx12_scoreboard unexpected word got %h required none", rx_data12);
            end else begin
                e12 = q12.pop_front();
                if (rx_data12 !== e12) begin
                    errors++;
                    $display("FAIL rx12_scoreboard got %h required %h", rx_data12, e12);
                end
            end
        end
        if (rx_valid8 === 1'b1) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL rx8_scoreboard unexpected word got %h required none", rx_data8);
            end else begin
                e8 = q8.pop_front();
                if (rx_data8 !== e8) begin
                    errors++;
                    $display("FAIL rx8_scoreboard got %h required %h", rx_data8, e8);
                end
            end
        end
        if (frame_err12 === 1'b1) ferr12++;
        if (tx_underrun12 === 1'b1) und12++;
    endtask

    // Drives nbits of w LSB-first on the 12-bit instance, capturing miso before each edge.
    task automatic frame12(input logic [11:0] w, input int nbits, input bit push,
                           output logic [11:0] mw, output int early);
        mw = '0;
        early = 0;
        if (push) q12.push_back(w);
        for (int i = 0; i < nbits; i++) begin
            cs12 = 1'b0;
            mosi12 = w[i];
            #1;
            mw[i] = miso12;
            tick();
            if (i < nbits - 1 && rx_valid12 === 1'b1) early++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({tx_pending12, rx_valid12, busy12, frame_err12, tx_underrun12, miso12} !== 6'b0 ||
            rx_data12 !== 12'h000) begin
            errors++;
            $display("FAIL reset12 flags %b data %h required 000000 000",
                     {tx_pending12, rx_valid12, busy12, frame_err12, tx_underrun12, miso12}, rx_data12);
        end
        checks++;
        if ({tx_pending8, rx_valid8, busy8, frame_err8, tx_underrun8, miso8} !== 6'b0 ||
            rx_data8 !== 8'h00) begin
            errors++;
            $display("FAIL reset8 flags %b data %h required 000000 00",
                     {tx_pending8, rx_valid8, busy8, frame_err8, tx_underrun8, miso8}, rx_data8);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_rx();
        logic [11:0] mw;
        int          early;
        frame12(12'hA5C, 12, 1'b1, mw, early);
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL basic_early_valid got %0d required 0", early);
        end
        checks++;
        if (rx_valid12 !== 1'b1 || frame_err12 !== 1'b0 || busy12 !== 1'b1) begin
            errors++;
            $display("FAIL basic_last_edge valid/err/busy %b%b%b required 101", rx_valid12, frame_err12, busy12);
        end
        cs12 = 1'b1;
        tick();
        checks++;
        if (rx_valid12 !== 1'b0 || frame_err12 !== 1'b0 || busy12 !== 1'b0 || rx_data12 !== 12'hA5C) begin
            errors++;
            $display("FAIL basic_clean_end valid/err/busy %b%b%b data %h required 000 a5c",
                     rx_valid12, frame_err12, busy12, rx_data12);
        end
    endtask

    task automatic test_duplex();
        logic [7:0] mw;
        logic [7:0] w;
        logic       pend_after_start;
        w = 8'h81;
        pend_after_start = 1'b1;
        tx_load8 = 1'b1;
        tx_data8 = 8'h3C;
        tick();
        tx_load8 = 1'b0;
        checks++;
        if (tx_pending8 !== 1'b1) begin
            errors++;
            $display("FAIL duplex_pending_set got %b required 1", tx_pending8);
        end
        tick();
        tick();
        checks++;
        if (miso8 !== 1'b0) begin
            errors++;
            $display("FAIL duplex_miso_idle got %b required 0", miso8);
        end
        q8.push_back(w);
        mw = '0;
        for (int i = 0; i < 8; i++) begin
            cs8 = 1'b0;
            mosi8 = w[7-i];
            #1;
            mw[7-i] = miso8;
            tick();
            if (i == 0) pend_after_start = tx_pending8;
        end
        checks++;
        if (pend_after_start !== 1'b0) begin
            errors++;
            $display("FAIL duplex_pending_clear got %b required 0", pend_after_start);
        end
        checks++;
        if (rx_valid8 !== 1'b1) begin
            errors++;
            $display("FAIL duplex_rx_valid got %b required 1", rx_valid8);
        end
        checks++;
        if (mw !== 8'h3C) begin
            errors++;
            $display("FAIL duplex_miso_seq got %b required 00111100", mw);
        end
        cs8 = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [23:0] stream;
        logic [11:0] mw;
        logic        und0, und11;
        int          nv, v_first, v_second, und_b, und_mid;
        stream = {12'hFED, 12'h123};
        mw = '0;
        und0 = 1'b0;
        und11 = 1'b0;
        nv = 0;
        v_first = -1;
        v_second = -1;
        und_mid = 0;
        tx_load12 = 1'b1;
        tx_data12 = 12'h6B7;
        tick();
        tx_load12 = 1'b0;
        tick();
        tick();
        q12.push_back(12'h123);
        q12.push_back(12'hFED);
        und_b = und12;
        for (int i = 0; i < 24; i++) begin
            cs12 = 1'b0;
            mosi12 = stream[i];
            #1;
            if (i < 12) mw[i] = miso12;
            tick();
            if (rx_valid12 === 1'b1) begin
                if (nv == 0) v_first = i;
                else v_second = i;
                nv++;
            end
            if (i == 0) und0 = tx_underrun12;
            if (i == 11) und11 = tx_underrun12;
            if (i == 22) und_mid = und12 - und_b;
        end
        checks++;
        if (nv != 2 || v_first != 11 || v_second - v_first != 12) begin
            errors++;
            $display("FAIL b2b_valid_timing count %0d at %0d,%0d required 2 at 11,23", nv, v_first, v_second);
        end
        checks++;
        if (und0 !== 1'b0 || und11 !== 1'b1 || und_mid != 1) begin
            errors++;
            $display("FAIL b2b_underrun first %b second %b count %0d required 0 1 1", und0, und11, und_mid);
        end
        checks++;
        if (mw !== 12'h6B7) begin
            errors++;
            $display("FAIL b2b_miso got %h required 6b7", mw);
        end
        cs12 = 1'b1;
        tick();
    endtask

    task automatic test_abort();
        logic [11:0] mw;
        int          early;
        frame12(12'h3A5, 5, 1'b0, mw, early);
        cs12 = 1'b1;
        tick();
        checks++;
        if (frame_err12 !== 1'b1 || rx_data12 !== 12'hFED || busy12 !== 1'b0 || rx_valid12 !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse err %b data %h busy %b valid %b required 1 fed 0 0",
                     frame_err12, rx_data12, busy12, rx_valid12);
        end
        tick();
        checks++;
        if (frame_err12 !== 1'b0) begin
            errors++;
            $display("FAIL abort_one_cycle got %b required 0", frame_err12);
        end
        frame12(12'h2C7, 12, 1'b1, mw, early);
        checks++;
        if (rx_valid12 !== 1'b1 || early != 0) begin
            errors++;
            $display("FAIL abort_followup valid %b early %0d required 1 0", rx_valid12, early);
        end
        cs12 = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [11:0] mw;
        int          early;
        int          ferr_b;
        frame12(12'h9D1, 7, 1'b0, mw, early);
        ferr_b = ferr12;
        rst = 1'b1;
        tick();
        checks++;
        if ({tx_pending12, rx_valid12, busy12, frame_err12, tx_underrun12, miso12} !== 6'b0 ||
            rx_data12 !== 12'h000) begin
            errors++;
            $display("FAIL midreset_outputs flags %b data %h required 000000 000",
                     {tx_pending12, rx_valid12, busy12, frame_err12, tx_underrun12, miso12}, rx_data12);
        end
        rst = 1'b0;
        cs12 = 1'b1;
        tick();
        checks++;
        if (ferr12 != ferr_b || rx_valid12 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_err frame_err pulses %0d valid %b required 0 0", ferr12 - ferr_b, rx_valid12);
        end
        frame12(12'h0F0, 12, 1'b1, mw, early);
        checks++;
        if (rx_valid12 !== 1'b1 || rx_data12 !== 12'h0F0) begin
            errors++;
            $display("FAIL midreset_followup valid %b data %h required 1 0f0", rx_valid12, rx_data12);
        end
        cs12 = 1'b1;
        tick();
    endtask

    task automatic test_sim_load();
        logic [11:0] w;
        logic [11:0] mw;
        logic [11:0] mw2;
        logic        pend0;
        int          early;
        w = 12'h4E1;
        mw = '0;
        pend0 = 1'b0;
        tx_load12 = 1'b1;
        tx_data12 = 12'hAAA;
        tick();
        tx_load12 = 1'b0;
        tick();
        tick();
        q12.push_back(w);
        for (int i = 0; i < 12; i++) begin
            cs12 = 1'b0;
            mosi12 = w[i];
            tx_load12 = (i == 0);
            tx_data12 = 12'h555;
            #1;
            mw[i] = miso12;
            tick();
            tx_load12 = 1'b0;
            if (i == 0) pend0 = tx_pending12;
        end
        checks++;
        if (pend0 !== 1'b1) begin
            errors++;
            $display("FAIL simload_pending got %b required 1", pend0);
        end
        checks++;
        if (mw !== 12'hAAA) begin
            errors++;
            $display("FAIL simload_old_word got %h required aaa", mw);
        end
        cs12 = 1'b1;
        tick();
        tick();
        frame12(12'h1B4, 12, 1'b1, mw2, early);
        checks++;
        if (mw2 !== 12'h555) begin
            errors++;
            $display("FAIL simload_new_word got %h required 555", mw2);
        end
        cs12 = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_rx();
        test_duplex();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_sim_load();
        checks++;
        if (q12.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d/%0d required 0/0", q12.size(), q8.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
